bp_be_dcache_plru_array: RTL and testbench

Per-set tree-PLRU state store and victim selector for the D$. It generalises the fixed 8-way update decode to any power-of-two associativity and any set count. It holds (ways_p-1) PLRU bits per set, updates them on hit/fill touches, and returns a registered victim way on request, preferring invalid ways. It sits beside the tag/data arrays in the dcache and is read by the miss/fill path.

---
 rtl/bp_be_dcache_plru_array.sv | 190 +++++++++++++++++++
 tb/tb_bp_be_dcache_plru_array.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_plru_array.sv
// Tree-PLRU state store and victim selector for the D$, one (ways_p-1)-bit
// tree per set, swept to zero after reset, with a registered victim result.
module bp_be_dcache_plru_array #(
  parameter  int ways_p     = 8,
  parameter  int sets_p     = 64,
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  output logic                  ready_o,
  input  logic                  touch_v_i,
  input  logic [lg_sets_lp-1:0] touch_set_i,
  input  logic [lg_ways_lp-1:0] touch_way_i,
  input  logic                  victim_v_i,
  input  logic [lg_sets_lp-1:0] victim_set_i,
  input  logic [ways_p-1:0]     invalid_mask_i,
  output logic                  victim_v_o,
  output logic [lg_ways_lp-1:0] victim_way_o,
  output logic                  victim_invalid_o
);

  typedef enum logic [0:0] {
    e_init  = 1'b0,
    e_ready = 1'b1
  } state_e;

  localparam logic [lg_sets_lp-1:0] last_set_lp = lg_sets_lp'(sets_p - 1);

  state_e                state_q, state_d;
  logic [lg_sets_lp-1:0] cnt_q, cnt_d;
  logic                  victim_v_q, victim_v_d;
  logic [lg_ways_lp-1:0] victim_way_q, victim_way_d;
  logic                  victim_invalid_q, victim_invalid_d;

  logic [ways_p-2:0]     plru_mem_q [sets_p];

  logic                  mem_we_s;
  logic [lg_sets_lp-1:0] mem_waddr_s;
  logic [ways_p-2:0]     mem_wdata_s;
  logic [lg_sets_lp-1:0] touch_idx_s, victim_idx_s;
  logic                  touch_ok_s;
  logic [ways_p-2:0]     touch_row_s, victim_row_s;

  // Single-set designs ignore the set index; out-of-range indices map to set 0.
  function automatic logic [lg_sets_lp-1:0] set_idx(input logic [lg_sets_lp-1:0] s);
    logic [lg_sets_lp-1:0] r;
    if (sets_p == 1) begin
      r = '0;
    end else if (int'(s) < sets_p) begin
      r = s;
    end else begin
      r = '0;
    end
    return r;
  endfunction

  function automatic logic [ways_p-2:0] touch_update(input logic [ways_p-2:0] row,
                                                     input logic [lg_ways_lp-1:0] way);
    logic [ways_p-2:0] upd;
    logic              b;
    int                node;
    upd  = row;
    node = 0;
    for (int l = 0; l < lg_ways_lp; l++) begin
      b         = way[lg_ways_lp-1-l];
      upd[node] = ~b;
      node      = 2 * node + 1 + int'(b);
    end
    return upd;
  endfunction

  function automatic logic [lg_ways_lp-1:0] plru_walk(input logic [ways_p-2:0] row);
    logic [lg_ways_lp-1:0] way;
    logic                  b;
    int                    node;
    way  = '0;
    node = 0;
    for (int l = 0; l < lg_ways_lp; l++) begin
      b                     = row[node];
      way[lg_ways_lp-1-l]   = b;
      node                  = 2 * node + 1 + int'(b);
    end
    return way;
  endfunction

  function automatic logic [lg_ways_lp-1:0] lowest_set(input logic [ways_p-1:0] mask);
    logic [lg_ways_lp-1:0] idx;
    idx = '0;
    for (int i = ways_p - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = lg_ways_lp'(i);
      end
    end
    return idx;
  endfunction

  assign touch_idx_s  = set_idx(touch_set_i);
  assign victim_idx_s = set_idx(victim_set_i);
  assign touch_ok_s   = (sets_p == 1) || (int'(touch_set_i) < sets_p);
  assign touch_row_s  = plru_mem_q[touch_idx_s];
  assign victim_row_s = plru_mem_q[victim_idx_s];

  // Next-state, sweep counter and victim result; lookup reads pre-touch state.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    victim_v_d       = 1'b0;
    victim_way_d     = victim_way_q;
    victim_invalid_d = victim_invalid_q;
    case (state_q)
      e_init: begin
        if (cnt_q == last_set_lp) begin
          state_d = e_ready;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + lg_sets_lp'(1);
        end
      end
      e_ready: begin
        if (victim_v_i) begin
          victim_v_d = 1'b1;
          if (|invalid_mask_i) begin
            victim_way_d     = lowest_set(invalid_mask_i);
            victim_invalid_d = 1'b1;
          end else begin
            victim_way_d     = plru_walk(victim_row_s);
            victim_invalid_d = 1'b0;
          end
        end else begin
          victim_v_d = 1'b0;
        end
      end
      default: begin
        state_d = e_init;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory write port: sweep clears during INIT, touches update during READY.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (!reset_n_i) begin
      mem_we_s = 1'b0;
    end else if (state_q == e_init) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = '0;
    end else if (touch_v_i && touch_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = touch_idx_s;
      mem_wdata_s = touch_update(touch_row_s, touch_way_i);
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q          <= e_init;
      cnt_q            <= '0;
      victim_v_q       <= 1'b0;
      victim_way_q     <= '0;
      victim_invalid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      victim_v_q       <= victim_v_d;
      victim_way_q     <= victim_way_d;
      victim_invalid_q <= victim_invalid_d;
    end
  end

  // PLRU bit storage; cleared by the sweep rather than by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      plru_mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign ready_o          = (state_q == e_ready);
  assign victim_v_o       = victim_v_q;
  assign victim_way_o     = victim_way_q;
  assign victim_invalid_o = victim_invalid_q;

endmodule

// File: tb/tb_bp_be_dcache_plru_array.sv
// Directed bench for bp_be_dcache_plru_array: 8-way/64-set instance driven by
// a vector table plus reset sequences, and a 4-way/1-set instance.
module tb_bp_be_dcache_plru_array;

  logic       clk;
  logic       rst_n;
  logic       ready;
  logic       touch_v;
  logic [5:0] touch_set;
  logic [2:0] touch_way;
  logic       victim_v;
  logic [5:0] victim_set;
  logic [7:0] mask;
  logic       vo;
  logic [2:0] vway;
  logic       vinv;

  logic       rst2_n;
  logic       ready2;
  logic       touch2_v;
  logic [0:0] touch2_set;
  logic [1:0] touch2_way;
  logic       victim2_v;
  logic [0:0] victim2_set;
  logic [3:0] mask2;
  logic       vo2;
  logic [1:0] vway2;
  logic       vinv2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       tv;
    logic [5:0] ts;
    logic [2:0] tw;
    logic       vv;
    logic [5:0] vs;
    logic [7:0] m;
    logic       ev;
    logic [2:0] ew;
    logic       ei;
  } vec_t;

  vec_t vecs[$];

  bp_be_dcache_plru_array #(.ways_p(8), .sets_p(64)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready),
    .touch_v_i(touch_v), .touch_set_i(touch_set), .touch_way_i(touch_way),
    .victim_v_i(victim_v), .victim_set_i(victim_set), .invalid_mask_i(mask),
    .victim_v_o(vo), .victim_way_o(vway), .victim_invalid_o(vinv)
  );

  bp_be_dcache_plru_array #(.ways_p(4), .sets_p(1)) dut2 (
    .clk_i(clk), .reset_n_i(rst2_n), .ready_o(ready2),
    .touch_v_i(touch2_v), .touch_set_i(touch2_set), .touch_way_i(touch2_way),
    .victim_v_i(victim2_v), .victim_set_i(victim2_set), .invalid_mask_i(mask2),
    .victim_v_o(vo2), .victim_way_o(vway2), .victim_invalid_o(vinv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic tv, input logic [5:0] ts, input logic [2:0] tw,
                     input logic vv, input logic [5:0] vs, input logic [7:0] m,
                     input logic ev, input logic [2:0] ew, input logic ei);
    vec_t v;
    v = '{tv: tv, ts: ts, tw: tw, vv: vv, vs: vs, m: m, ev: ev, ew: ew, ei: ei};
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      touch_v    = vecs[i].tv;
      touch_set  = vecs[i].ts;
      touch_way  = vecs[i].tw;
      victim_v   = vecs[i].vv;
      victim_set = vecs[i].vs;
      mask       = vecs[i].m;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].v", tag, i), 32'(vo), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("%s[%0d].way", tag, i), 32'(vway), 32'(vecs[i].ew));
        check($sformatf("%s[%0d].inv", tag, i), 32'(vinv), 32'(vecs[i].ei));
      end
    end
    vecs.delete();
    touch_v  = 1'b0;
    victim_v = 1'b0;
    mask     = 8'h00;
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s.ready@%0d", tag, k), 32'(ready), 32'(k == 64));
      check($sformatf("%s.v@%0d", tag, k), 32'(vo), 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; touch_v = 1'b0; touch_set = 6'd0; touch_way = 3'd0;
    victim_v = 1'b0; victim_set = 6'd0; mask = 8'h00;
    rst2_n = 1'b0; touch2_v = 1'b0; touch2_set = 1'b0; touch2_way = 2'd0;
    victim2_v = 1'b0; victim2_set = 1'b0; mask2 = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(ready), 32'h0);
    check("rst.v", 32'(vo), 32'h0);
    check("rst.way", 32'(vway), 32'h0);
    check("rst.inv", 32'(vinv), 32'h0);

    // Release with a victim request held throughout INIT.
    rst_n = 1'b1; victim_v = 1'b1; victim_set = 6'd5;
    sweep_check("init");
    victim_v = 1'b0;

    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd6, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b1, 6'd5, 3'd0, 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd5, 8'h00, 1'b1, 3'd4, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd6, 8'h00, 1'b1, 3'd0, 1'b0);
    for (int w = 0; w < 8; w++) add(1'b1, 6'd9, 3'(w), 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd9, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b1, 6'd9, 3'd0, 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd9, 8'h00, 1'b1, 3'd4, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd3, 8'h24, 1'b1, 3'd2, 1'b1);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd3, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b1, 6'd2, 3'd0, 1'b1, 6'd2, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd2, 8'h00, 1'b1, 3'd4, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd2, 8'h80, 1'b1, 3'd7, 1'b1);
    add(1'b1, 6'd10, 3'd4, 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b1, 6'd10, 3'd0, 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd10, 8'h00, 1'b1, 3'd6, 1'b0);
    add(1'b1, 6'd63, 3'd2, 1'b1, 6'd62, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd63, 8'h00, 1'b1, 3'd4, 1'b0);
    add(1'b1, 6'd0, 3'd6, 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b1, 6'd0, 3'd1, 1'b0, 6'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd0, 8'h00, 1'b1, 3'd4, 1'b0);
    run_vecs("main");

    // Reset in READY with a lookup in flight.
    victim_v = 1'b1; victim_set = 6'd5; mask = 8'h00;
    @(posedge clk);
    #1;
    check("flight.v", 32'(vo), 32'h1);
    check("flight.way", 32'(vway), 32'h4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("flight.drop_v", 32'(vo), 32'h0);
    check("flight.ready", 32'(ready), 32'h0);
    check("flight.way_rst", 32'(vway), 32'h0);
    rst_n = 1'b1; victim_v = 1'b0;

    // Reset again at INIT cycle 20; the sweep restarts from set 0.
    repeat (20) @(posedge clk);
    #1;
    check("mid_init.ready", 32'(ready), 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_init.rst_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    sweep_check("resweep");

    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd5, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd9, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd2, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd10, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd63, 8'h00, 1'b1, 3'd0, 1'b0);
    add(1'b0, 6'd0, 3'd0, 1'b1, 6'd0, 8'h00, 1'b1, 3'd0, 1'b0);
    run_vecs("post");

    // 4-way, single-set instance.
    #1;
    check("d2.rst_ready", 32'(ready2), 32'h0);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    check("d2.ready", 32'(ready2), 32'h1);
    touch2_v = 1'b1; touch2_set = 1'b1; touch2_way = 2'd1;
    @(posedge clk);
    #1;
    touch2_v = 1'b0;
    victim2_v = 1'b1; victim2_set = 1'b0; mask2 = 4'h0;
    @(posedge clk);
    #1;
    check("d2.v", 32'(vo2), 32'h1);
    check("d2.way", 32'(vway2), 32'h2);
    check("d2.inv", 32'(vinv2), 32'h0);
    mask2 = 4'b1010;
    @(posedge clk);
    #1;
    check("d2.inv_way", 32'(vway2), 32'h1);
    check("d2.inv_flag", 32'(vinv2), 32'h1);
    victim2_v = 1'b0; mask2 = 4'h0;
    @(posedge clk);
    #1;
    check("d2.idle_v", 32'(vo2), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
